// File: rtl/pll_lock_reset_ctrl_if.sv
// PLL-side and system-side signal bundle of the PLL lock/reset controller.
// The master modport is the controller; the slave modport is the PLL/system side.
`timescale 1ns/1ps
interface pll_lock_reset_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             pll_locked;
  logic             pll_rst;
  logic             sys_rst;
  logic             ready;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] timeout_count;
  logic [CNT_W-1:0] lock_loss_count;

  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_rst,
    output ready,
    output state_o,
    output timeout_count,
    output lock_loss_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  state_o,
    input  timeout_count,
    input  lock_loss_count
  );
endinterface

// File: rtl/pll_lock_reset_ctrl.sv
// PLL reset sequencer on the free-running reference clock: pulses the PLL reset, waits
// for a stable lock, then releases the system reset; counts lock timeouts and lock losses.
`timescale 1ns/1ps
module pll_lock_reset_ctrl #(
  parameter int unsigned PLL_RST_CYCLES      = 10,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1000,
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned CNT_W               = 8
) (
  input  logic                 refclk,
  input  logic                 rst,
  pll_lock_reset_ctrl_if.master bus
);

  localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
  localparam int unsigned PW      = $clog2(CNT_MAX + 1);

  localparam logic [PW-1:0] PH_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] PH_ONE   = PW'(1);
  localparam logic [PW-1:0] RST_LAST = PW'(PLL_RST_CYCLES - 1);
  localparam logic [PW-1:0] TO_LAST  = PW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] STB_LAST = PW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [PW-1:0] BLANK    = PW'(SYNC_STAGES);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       tc_q, tc_d;
  logic [CNT_W-1:0]       llc_q, llc_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   ready_q, ready_d;
  logic                   locked_s;

  // Event counters stick at all-ones so a storm of events never reads back as a small count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
  assign locked_s = sync_q[SYNC_STAGES-1];

  // Next state, phase counter and event counters; outputs decoded from the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tc_d    = tc_q;
    llc_d   = llc_q;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = PH_ZERO;
        end else begin
          cnt_d   = cnt_q + PH_ONE;
        end
      end
      S_WAIT_LOCK: begin
        // Lock is checked ahead of the timeout so it wins a tie; the first SYNC_STAGES
        // cycles still carry the pre-reset lock level and are ignored.
        if ((cnt_q >= BLANK) && locked_s) begin
          state_d = S_STABLE;
          cnt_d   = PH_ZERO;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_PLL_RST;
          cnt_d   = PH_ZERO;
          tc_d    = sat_inc(tc_q);
        end else begin
          cnt_d   = cnt_q + PH_ONE;
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = PH_ZERO;
        end else if (cnt_q == STB_LAST) begin
          state_d = S_RUN;
          cnt_d   = PH_ZERO;
        end else begin
          cnt_d   = cnt_q + PH_ONE;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d = S_PLL_RST;
          cnt_d   = PH_ZERO;
          llc_d   = sat_inc(llc_q);
        end else begin
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = PH_ZERO;
      end
    endcase
    pll_rst_d = (state_d == S_PLL_RST);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
  end

  // State, synchronizer, counters and registered outputs
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= PH_ZERO;
      sync_q    <= {SYNC_STAGES{1'b0}};
      tc_q      <= {CNT_W{1'b0}};
      llc_q     <= {CNT_W{1'b0}};
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync_q    <= sync_d;
      tc_q      <= tc_d;
      llc_q     <= llc_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.pll_rst         = pll_rst_q;
  assign bus.sys_rst         = sys_rst_q;
  assign bus.ready           = ready_q;
  assign bus.state_o         = state_q;
  assign bus.timeout_count   = tc_q;
  assign bus.lock_loss_count = llc_q;

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Directed bench for pll_lock_reset_ctrl: expected output vectors are queued per cycle
// and compared on the falling edge; cycle k is the sample taken just before edge k.
`timescale 1ns/1ps
module tb_pll_lock_reset_ctrl;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;

  logic [20:0] exp_q[$];
  string       tag_q[$];

  pll_lock_reset_ctrl_if #(.CNT_W(8)) bus ();

  pll_lock_reset_ctrl #(
    .PLL_RST_CYCLES      (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .SYNC_STAGES         (2),
    .CNT_W               (8)
  ) dut (
    .refclk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Output vector implied by a state: pll_rst only in PLL_RST, sys_rst low and ready high only in RUN
  function automatic logic [20:0] exp_vec(input logic [1:0] st, input logic [7:0] tc,
                                          input logic [7:0] llc);
    exp_vec = {st, (st == 2'd0), (st != 2'd3), (st == 2'd3), tc, llc};
  endfunction

  // Boot sequence with lock present: PLL_RST 0-3, WAIT_LOCK 4-6, STABLE 7-14, RUN from 15
  function automatic logic [1:0] boot_st(input int c);
    if (c < 4)       boot_st = 2'd0;
    else if (c < 7)  boot_st = 2'd1;
    else if (c < 15) boot_st = 2'd2;
    else             boot_st = 2'd3;
  endfunction

  task automatic push(input string tag, input logic [1:0] st, input logic [7:0] tc,
                      input logic [7:0] llc);
    exp_q.push_back(exp_vec(st, tc, llc));
    tag_q.push_back(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_one();
    logic [20:0] obs;
    logic [20:0] exp_v;
    string       tag;
    obs = {bus.state_o, bus.pll_rst, bus.sys_rst, bus.ready,
           bus.timeout_count, bus.lock_loss_count};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL sb_underflow cyc=%0d observed=%h expected=none", cyc, obs);
    end else begin
      exp_v = exp_q.pop_front();
      tag   = tag_q.pop_front();
      assert (obs === exp_v) else begin
        fails++;
        $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      check_one();
      tick();
    end
  endtask

  task automatic wait_ready(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (bus.ready === 1'b1) break;
      tick();
    end
    tests++;
    assert (bus.ready === 1'b1) else begin
      fails++;
      $error("FAIL wait_ready_timeout cyc=%0d observed=%b expected=1", cyc, bus.ready);
    end
  endtask

  task automatic do_reset(input logic lock);
    @(negedge clk);
    rst = 1'b1;
    bus.pll_locked = lock;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d observed=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus.pll_locked = 1'b0;

    // Boot with lock already high
    do_reset(1'b1);
    for (int c = 0; c < 20; c++) push("t1_boot", boot_st(c), 8'd0, 8'd0);
    run(20);

    // Lock loss in RUN: one-cycle low at offset 0 reaches locked_s at offset 2, PLL_RST at 3
    bus.pll_locked = 1'b0;
    for (int o = 0; o < 21; o++) begin
      if (o < 3)       push("t4_loss", 2'd3, 8'd0, 8'd0);
      else if (o < 7)  push("t4_loss", 2'd0, 8'd0, 8'd1);
      else if (o < 10) push("t4_loss", 2'd1, 8'd0, 8'd1);
      else if (o < 18) push("t4_loss", 2'd2, 8'd0, 8'd1);
      else             push("t4_loss", 2'd3, 8'd0, 8'd1);
    end
    run(1);
    bus.pll_locked = 1'b1;
    run(20);

    // Repeated lock losses drive lock_loss_count into saturation
    for (int i = 1; i <= 301; i++) begin
      int v;
      bus.pll_locked = 1'b0;
      tick();
      bus.pll_locked = 1'b1;
      repeat (4) tick();
      wait_ready(40);
      v = (1 + i > 255) ? 255 : 1 + i;
      push("t5_llc_sat", 2'd3, 8'd0, 8'(v));
      check_one();
    end

    // One-cycle reset while in RUN, then the boot timing repeats
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
    for (int c = 0; c < 20; c++) push("t6_rst_run", boot_st(c), 8'd0, 8'd0);
    run(20);

    // No lock: 24-cycle PLL_RST/WAIT_LOCK period, timeout counted on each period end
    do_reset(1'b0);
    for (int c = 0; c <= 300; c++) begin
      push("t2_timeout", ((c % 24) < 4) ? 2'd0 : 2'd1, 8'(c / 24), 8'd0);
    end
    run(301);

    // Lock dropout in STABLE after five high cycles returns to WAIT_LOCK without a PLL reset
    do_reset(1'b1);
    for (int c = 0; c < 28; c++) begin
      if (c < 12)      push("t3_stable_drop", boot_st(c), 8'd0, 8'd0);
      else if (c < 13) push("t3_stable_drop", 2'd2, 8'd0, 8'd0);
      else if (c < 16) push("t3_stable_drop", 2'd1, 8'd0, 8'd0);
      else if (c < 24) push("t3_stable_drop", 2'd2, 8'd0, 8'd0);
      else             push("t3_stable_drop", 2'd3, 8'd0, 8'd0);
    end
    run(10);
    bus.pll_locked = 1'b0;
    run(1);
    bus.pll_locked = 1'b1;
    run(17);

    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
